mod_multiplier_barrett_pipe: RTL and testbench

- Parametrised, fully pipelined Barrett modular multiplier: oData = (iData0 * iData1) mod iMod, with valid/tag tracking, stall (iEn) and flush (iClr).
- Successor to the fixed 64-bit multiplier. Operand width is generic, and modulus/K/U are sampled per transaction, so the modulus can change back-to-back without a drain.
- Sits in the NTT/polynomial-arithmetic datapath between operand fetch and the butterfly/accumulate stage.

---
 rtl/mod_mult_pkg.sv | 12 +
 rtl/mod_sub_cond.sv | 37 +++
 rtl/mod_multiplier_barrett_pipe.sv | 161 ++++++++++++++++
 tb/tb_mod_multiplier_barrett_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_mult_pkg.sv
// Shared constants for the pipelined Barrett modular multiplier.
package mod_mult_pkg;

  // Register stages from input capture to the output registers.
  localparam int unsigned LATENCY = 6;

  // Width of the q1*U product, which is wide enough to hold 2^(2k+2).
  function automatic int unsigned inter_w(input int unsigned data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/mod_sub_cond.sv
// One conditional-subtract correction stage: res <= (r >= m) ? r - m : r.
// A bubble, flush or reset leaves zero in the register.
module mod_sub_cond #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RES_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              valid,
  input  logic [DATA_W-1:0] m,
  input  logic [DATA_W+1:0] r,
  output logic [RES_W-1:0]  res
);

  localparam int unsigned R_W = DATA_W + 2;

  logic [R_W-1:0] m_ext_c;
  logic [R_W-1:0] nxt_c;

  // Single correction step.
  always_comb begin
    m_ext_c = R_W'(m);
    nxt_c   = (r >= m_ext_c) ? (r - m_ext_c) : r;
  end

  // Stage register: zero on reset, flush or bubble; held while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      res <= '0;
    end else if (en) begin
      res <= valid ? RES_W'(nxt_c) : '0;
    end
  end

endmodule

// File: rtl/mod_multiplier_barrett_pipe.sv
// Fully pipelined Barrett modular multiplier: oData = (iData0 * iData1) mod iMod.
// Modulus, k and U travel with each transaction, so the modulus may change every cycle.
// Optional macro MOD_MULT_BARRETT_RANGE_CHECK_EN adds oErr for out-of-range operands.
module mod_multiplier_barrett_pipe
  import mod_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned K_W    = $clog2(DATA_W) + 1
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iEn,
  input  logic                  iClr,
  input  logic                  iValid,
  input  logic [TAG_W-1:0]      iTag,
  input  logic [K_W-1:0]        iK,
  input  logic [2*DATA_W-1:0]   iU,
  input  logic [DATA_W-1:0]     iData0,
  input  logic [DATA_W-1:0]     iData1,
  input  logic [DATA_W-1:0]     iMod,
  output logic                  oValid,
  output logic [TAG_W-1:0]      oTag,
  output logic [DATA_W-1:0]     oData
`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
  ,
  output logic                  oErr
`endif
);

  localparam int unsigned P_W  = 2 * DATA_W;
  localparam int unsigned M_W  = inter_w(DATA_W);
  localparam int unsigned R_W  = DATA_W + 2;
  localparam int unsigned KS_W = K_W + 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] m;
    logic [K_W-1:0]    k;
    logic [P_W-1:0]    u;
  } side_t;

  side_t             side_in_c;
  side_t             side_q [LATENCY];

  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [P_W-1:0]    p1;
  logic [R_W-1:0]    p2_lo;
  logic [M_W-1:0]    m2;
  logic [R_W-1:0]    r3;
  logic [R_W-1:0]    r4;

  logic [K_W-1:0]    km1_c;
  logic [M_W-1:0]    q1_c;
  logic [KS_W-1:0]   ksh_c;
  logic [R_W-1:0]    q_lo_c;
  logic [R_W-1:0]    qm_c;
  logic              unused_c;

  // Sideband for the capture stage; bubbles enter as all-zero.
  always_comb begin
    side_in_c = '0;
    if (iValid) begin
      side_in_c.valid = 1'b1;
      side_in_c.tag   = iTag;
      side_in_c.m     = iMod;
      side_in_c.k     = iK;
      side_in_c.u     = iU;
    end
  end

  // Sideband shift chain; flush and reset clear every stage.
  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        side_q[i] <= '0;
      end
    end else if (iEn) begin
      side_q[0] <= side_in_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  // Barrett quotient estimate and reduced-width remainder terms.
  always_comb begin
    km1_c  = side_q[1].k - K_W'(1);
    q1_c   = M_W'(p1 >> km1_c);
    ksh_c  = KS_W'(side_q[2].k) + KS_W'(1);
    q_lo_c = R_W'(m2 >> ksh_c);
    qm_c   = q_lo_c * R_W'(side_q[2].m);
  end

  // Arithmetic stages S0..S3; validity is tracked by the sideband alone.
  always_ff @(posedge iClk) begin
    if (iEn) begin
      a0    <= iData0;
      b0    <= iData1;
      p1    <= P_W'(a0) * P_W'(b0);
      p2_lo <= p1[R_W-1:0];
      m2    <= q1_c * M_W'(side_q[1].u);
      r3    <= p2_lo - qm_c;
    end
  end

  mod_sub_cond #(
    .DATA_W (DATA_W),
    .RES_W  (R_W)
  ) u_sub_s4 (
    .clk   (iClk),
    .rst_n (iRstN),
    .en    (iEn),
    .clr   (iClr),
    .valid (side_q[3].valid),
    .m     (side_q[3].m),
    .r     (r3),
    .res   (r4)
  );

  mod_sub_cond #(
    .DATA_W (DATA_W),
    .RES_W  (DATA_W)
  ) u_sub_s5 (
    .clk   (iClk),
    .rst_n (iRstN),
    .en    (iEn),
    .clr   (iClr),
    .valid (side_q[4].valid),
    .m     (side_q[4].m),
    .r     (r4),
    .res   (oData)
  );

  assign oValid = side_q[LATENCY-1].valid;
  assign oTag   = side_q[LATENCY-1].tag;

  // Sideband fields that terminate at the output stage.
  assign unused_c = ^{side_q[LATENCY-1].m, side_q[LATENCY-1].k, side_q[LATENCY-1].u};

`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
  logic               err_in_c;
  logic [LATENCY-1:0] err_q;

  assign err_in_c = iValid & ((iData0 >= iMod) | (iData1 >= iMod) | (iMod < DATA_W'(2)));

  // Range-error flag follows the same reset/flush/stall rules as the valid bit.
  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      err_q <= '0;
    end else if (iEn) begin
      err_q <= {err_q[LATENCY-2:0], err_in_c};
    end
  end

  assign oErr = err_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_mod_multiplier_barrett_pipe.sv
// Self-checking bench for mod_multiplier_barrett_pipe (DATA_W=64, TAG_W=8).
module tb_mod_multiplier_barrett_pipe;

  localparam int unsigned W   = 64;
  localparam int unsigned TW  = 8;
  localparam int unsigned KW  = 7;
  localparam int unsigned LAT = 6;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            clr;
  logic            vld;
  logic [TW-1:0]   tag;
  logic [KW-1:0]   k;
  logic [2*W-1:0]  u;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    m;
  logic            o_valid;
  logic [TW-1:0]   o_tag;
  logic [W-1:0]    o_data;
`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
  logic            o_err;
`endif

  mod_multiplier_barrett_pipe #(
    .DATA_W (W),
    .TAG_W  (TW),
    .K_W    (KW)
  ) dut (
    .iClk   (clk),
    .iRstN  (rst_n),
    .iEn    (en),
    .iClr   (clr),
    .iValid (vld),
    .iTag   (tag),
    .iK     (k),
    .iU     (u),
    .iData0 (a),
    .iData1 (b),
    .iMod   (m),
    .oValid (o_valid),
    .oTag   (o_tag),
    .oData  (o_data)
`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
    ,
    .oErr   (o_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
    logic          err;
    logic          chk_data;
    logic          tag_zero;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   m;
    logic [KW-1:0]  k;
    logic [2*W-1:0] u;
    logic [W-1:0]   exp;
  } vec_t;

  localparam logic [W-1:0]   MAXM = 64'hffff_ffff_ffff_ffff;
  localparam logic [2*W-1:0] MAXU = {64'd1, 64'd1};

  exp_t          pipe_q[$];
  exp_t          cur;
  logic [TW-1:0] obs_q[$];
  int            checks;
  int            errors;

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] md);
    logic [2*W-1:0] p;
    if (md == '0) return '0;
    p = {64'd0, x} * {64'd0, y};
    return W'(p % {64'd0, md});
  endfunction

  function automatic logic [KW-1:0] calc_k(input logic [W-1:0] md);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (md[i]) return KW'(i + 1);
    end
    return '0;
  endfunction

  function automatic logic [2*W-1:0] calc_u(input logic [W-1:0] md, input logic [KW-1:0] kk);
    logic [255:0] num;
    if (md == '0) return '0;
    num = 256'(1) << (2 * int'(kk));
    return (2*W)'(num / {192'd0, md});
  endfunction

  function automatic exp_t bubble_rec(input logic tz);
    exp_t r;
    r.valid = 1'b0; r.tag = '0; r.data = '0; r.err = 1'b0; r.chk_data = 1'b0; r.tag_zero = tz;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: results emerge in input order, LAT enabled edges after capture.
  task automatic model_edge();
    exp_t r;
    if (!rst_n || clr) begin
      pipe_q.delete();
      for (int i = 0; i < int'(LAT) - 1; i++) pipe_q.push_back(bubble_rec(1'b0));
      cur = bubble_rec(1'b1);
    end else if (en) begin
      if (vld) begin
        r.valid    = 1'b1;
        r.tag      = tag;
        r.err      = (a >= m) || (b >= m) || (m < 64'd2);
        r.data     = mulmod(a, b, m);
        r.chk_data = !r.err;
        r.tag_zero = 1'b0;
      end else begin
        r = bubble_rec(1'b0);
      end
      pipe_q.push_back(r);
      cur = pipe_q.pop_front();
    end
  endtask

  task automatic check_out();
    chk("valid", (2*W)'(o_valid), (2*W)'(cur.valid));
    if (cur.valid) begin
      chk("tag", (2*W)'(o_tag), (2*W)'(cur.tag));
      if (cur.chk_data) chk("data", (2*W)'(o_data), (2*W)'(cur.data));
    end else begin
      chk("bubble_data", (2*W)'(o_data), '0);
      if (cur.tag_zero) chk("cleared_tag", (2*W)'(o_tag), '0);
    end
`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
    chk("err", (2*W)'(o_err), (2*W)'(cur.valid && cur.err));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_out();
    if (o_valid) obs_q.push_back(o_tag);
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] tg, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] md);
    vld = v; tag = tg; a = x; b = y; m = md;
    k = calc_k(md);
    u = calc_u(md, k);
  endtask

  task automatic bubbles(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_tags(input string nm, input int n, input int first);
    chk({nm, "_count"}, (2*W)'(obs_q.size()), (2*W)'(n));
    for (int i = 0; i < obs_q.size() && i < n; i++) chk({nm, "_order"}, (2*W)'(obs_q[i]), (2*W)'(first + i));
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] rm;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    clk = 1'b0; checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0;
    drive(1'b0, '0, '0, '0, 64'd7681);

    vecs[0] = '{a: 64'd1467, b: 64'd2489, m: 64'd7681, k: 7'd13, u: 128'd8736, exp: 64'd2888};
    vecs[1] = '{a: MAXM - 64'd1, b: MAXM - 64'd1, m: MAXM, k: 7'd64, u: MAXU, exp: 64'd1};
    vecs[2] = '{a: 64'd0, b: 64'h0123_4567_89ab_cdef, m: MAXM, k: 7'd64, u: MAXU, exp: 64'd0};
    vecs[3] = '{a: 64'd7680, b: 64'd7680, m: 64'd7681, k: 7'd13, u: 128'd8736, exp: 64'd1};
    vecs[4] = '{a: 64'd1, b: MAXM - 64'd1, m: MAXM, k: 7'd64, u: MAXU, exp: MAXM - 64'd1};
    vecs[5] = '{a: 64'd2, b: 64'h8000_0000_0000_0000, m: MAXM, k: 7'd64, u: MAXU, exp: 64'd1};

    // Reset state.
    tick(); tick();
    rst_n = 1'b1;

    // Small modulus held valid every cycle.
    vld = 1'b1; tag = 8'h5a; a = 64'd1467; b = 64'd2489; m = 64'd7681; k = 7'd13; u = 128'd8736;
    for (int i = 0; i < 12; i++) tick();
    chk("held_2888", (2*W)'(o_data), 128'd2888);
    bubbles(int'(LAT));

    // Table vectors, one at a time, with spec-supplied k and U.
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; tag = TW'(i); a = vecs[i].a; b = vecs[i].b; m = vecs[i].m;
      k = vecs[i].k; u = vecs[i].u;
      tick();
      bubbles(int'(LAT) - 1);
      chk("tbl_valid", (2*W)'(o_valid), 128'd1);
      chk("tbl_data", (2*W)'(o_data), (2*W)'(vecs[i].exp));
      chk("tbl_tag", (2*W)'(o_tag), (2*W)'(i));
    end

    // Random operands at the maximum modulus, back to back.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, TW'(8'h40 + i), {$urandom(), $urandom()} % MAXM, {$urandom(), $urandom()} % MAXM, MAXM);
      tick();
    end
    bubbles(int'(LAT));

    // Random moduli of random bit length.
    for (int i = 0; i < 30; i++) begin
      rm = {$urandom(), $urandom()} >> $urandom_range(0, 61);
      if (rm < 64'd2) rm = 64'd3;
      drive(1'b1, TW'(i), {$urandom(), $urandom()} % rm, {$urandom(), $urandom()} % rm, rm);
      tick();
    end
    bubbles(int'(LAT));

    // Alternate moduli every cycle; tags must emerge in order.
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      rm = (i % 2 == 0) ? 64'd7681 : MAXM;
      drive(1'b1, TW'(i), {$urandom(), $urandom()} % rm, {$urandom(), $urandom()} % rm, rm);
      tick();
    end
    bubbles(int'(LAT));
    check_tags("switch", 10, 0);

    // Stall mid-flight; inputs offered during the stall must be ignored.
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, TW'(20 + i), 64'd100 + 64'(i), 64'd200, 64'd7681);
      tick();
    end
    bubbles(1);
    en = 1'b0;
    drive(1'b1, 8'd99, 64'd5, 64'd6, 64'd7681);
    for (int i = 0; i < 4; i++) tick();
    en = 1'b1;
    bubbles(int'(LAT) + 2);
    check_tags("stall", 3, 20);

    // Flush with five in flight; the same-cycle input is dropped.
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, TW'(30 + i), 64'd7000 + 64'(i), 64'd7001, 64'd7681);
      tick();
    end
    clr = 1'b1;
    drive(1'b1, 8'd77, 64'd1, 64'd1, 64'd7681);
    tick();
    clr = 1'b0;
    chk("flush_valid", (2*W)'(o_valid), 128'd0);
    chk("flush_data", (2*W)'(o_data), 128'd0);
    bubbles(int'(LAT) + 1);
    check_tags("flush", 0, 0);

    // Reset mid-stream.
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, TW'(40 + i), MAXM - 64'(i + 1), MAXM - 64'd5, MAXM);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_valid", (2*W)'(o_valid), 128'd0);
    chk("rst_tag", (2*W)'(o_tag), 128'd0);
    bubbles(int'(LAT) + 1);
    check_tags("reset", 0, 0);

    // Out-of-contract operand: no hang, flag when built in.
    drive(1'b1, 8'h77, 64'd7681, 64'd3, 64'd7681);
    tick();
    bubbles(int'(LAT) - 1);
    chk("ooc_valid", (2*W)'(o_valid), 128'd1);
`ifdef MOD_MULT_BARRETT_RANGE_CHECK_EN
    chk("ooc_err", (2*W)'(o_err), 128'd1);
    drive(1'b1, 8'h78, 64'd3, 64'd3, 64'd7681);
    tick();
    bubbles(int'(LAT) - 1);
    chk("legal_err", (2*W)'(o_err), 128'd0);
    chk("legal_data", (2*W)'(o_data), 128'd9);
`endif
    bubbles(int'(LAT));

    // Random mix of stalls, bubbles, flushes and moduli.
    for (int i = 0; i < 300; i++) begin
      rm = ($urandom_range(0, 1) == 0) ? MAXM : ({$urandom(), $urandom()} >> $urandom_range(0, 60));
      if (rm < 64'd2) rm = 64'd2;
      ra = {$urandom(), $urandom()} % rm;
      rb = {$urandom(), $urandom()} % rm;
      drive($urandom_range(0, 3) != 0, TW'($urandom()), ra, rb, rm);
      en  = $urandom_range(0, 4) != 0;
      clr = $urandom_range(0, 40) == 0;
      tick();
    end
    en = 1'b1; clr = 1'b0;
    bubbles(int'(LAT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
